// File: rtl/snake_dir_scheduler_if.sv
// ---------------------------------------------------------------------------
// snake_dir_scheduler_if
//
// Groups the key/control inputs and the direction/timing outputs of the
// snake direction scheduler into a single bundle.
//
//   P_up/P_down/P_left/P_right : one-cycle key pulses from the PS/2 decoder
//   pause                      : one-cycle pulse, toggles RUN/PAUSE
//   game_over                  : level, forces IDLE and flushes the queue
//   dir                        : current snake direction (0 up,1 down,2 left,3 right)
//   move_tick                  : one-cycle pulse, movement engine advances
//   running                    : 1 while the scheduler is in RUN
//   q_count                    : direction FIFO occupancy
//   drop                       : one-cycle pulse, legal key lost (FIFO full)
//
// Modports:
//   master : drives keys/pause/game_over, observes the scheduler outputs
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface snake_dir_scheduler_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          P_up;
    logic          P_down;
    logic          P_left;
    logic          P_right;
    logic          pause;
    logic          game_over;
    logic [1:0]    dir;
    logic          move_tick;
    logic          running;
    logic [CW-1:0] q_count;
    logic          drop;

    modport master (
        output P_up, P_down, P_left, P_right, pause, game_over,
        input  dir, move_tick, running, q_count, drop
    );

    modport slave (
        input  P_up, P_down, P_left, P_right, pause, game_over,
        output dir, move_tick, running, q_count, drop
    );
endinterface

// File: rtl/snake_dir_scheduler.sv
// ---------------------------------------------------------------------------
// snake_dir_scheduler
//
// Sits between the PS/2 key decoder and the snake movement engine. Key
// pulses are filtered against the most recent direction (reversals and
// repeats are ignored), legal turns are buffered in a small FIFO, and at
// most one buffered turn is applied per move tick. The module also owns
// the move-tick timebase and an IDLE/RUN/PAUSE sequencer.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : snake_dir_scheduler_if.slave
//          inputs  P_up, P_down, P_left, P_right, pause, game_over
//          outputs dir, move_tick, running, q_count, drop
//
// Parameters:
//   TICK_DIV  : clk cycles per move tick (>= 2)
//   QDEPTH    : direction FIFO depth (power of 2, >= 2)
//   START_DIR : direction loaded on reset / game_over
// ---------------------------------------------------------------------------
module snake_dir_scheduler #(
    parameter int         TICK_DIV  = 5000000,
    parameter int         QDEPTH    = 4,
    parameter logic [1:0] START_DIR = 2'd3
) (
    input  logic                 clk,
    input  logic                 rst,
    snake_dir_scheduler_if.slave bus
);
    localparam int AW    = $clog2(QDEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       dir_q;
    logic             move_tick_q;
    logic             drop_q;
    logic             running_q;

    // Direction storage; pointers/occupancy are the only state needing reset.
    logic [1:0] mem [QDEPTH];

    logic       key_vld;
    logic [1:0] key;
    logic [1:0] ref_dir;
    logic [AW-1:0] tail_ptr;
    logic       legal;
    logic       full;
    logic       push;
    logic       drop_nxt;
    logic       count_en;
    logic       tick;
    logic       pop;

    // Key decode, legality filter and FIFO/timebase control.
    always_comb begin
        key_vld  = bus.P_up | bus.P_down | bus.P_left | bus.P_right;
        key      = 2'd3;
        if (bus.P_up)
            key = 2'd0;
        else if (bus.P_down)
            key = 2'd1;
        else if (bus.P_left)
            key = 2'd2;

        // Compare against the newest queued turn so a burst of keys chains
        // naturally; with an empty queue the live direction is the reference.
        tail_ptr = wr_ptr_q - AW'(1);
        ref_dir  = (count_q != '0) ? mem[tail_ptr] : dir_q;

        // Opposite directions share bit 1 and differ in bit 0.
        legal = key_vld && (key != ref_dir) &&
                !((key[1] == ref_dir[1]) && (key[0] != ref_dir[0]));

        full     = (count_q == CNT_FULL);
        push     = legal && !bus.game_over && !full;
        drop_nxt = legal && !bus.game_over && full;

        // The counter advances in RUN, and also on the very cycle PAUSE is
        // released, so resume continues from the frozen value without a gap.
        // A pause pulse in RUN freezes the counter on that same cycle.
        count_en = !bus.game_over &&
                   (((state_q == RUN) && !bus.pause) ||
                    ((state_q == PAUSE) && bus.pause));
        tick     = count_en && (cnt_q == CNT_LAST);
        pop      = tick && (count_q != '0);
    end

    // Sequencer next-state.
    always_comb begin
        state_d = state_q;
        if (bus.game_over) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (legal)     state_d = RUN;
                RUN:     if (bus.pause) state_d = PAUSE;
                PAUSE:   if (bus.pause) state_d = RUN;
                default:                state_d = IDLE;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dir_q       <= START_DIR;
            move_tick_q <= 1'b0;
            drop_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d == RUN);
            move_tick_q <= tick;
            drop_q      <= drop_nxt;

            if (bus.game_over) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                dir_q    <= START_DIR;
            end else begin
                if (state_q == IDLE || tick)
                    cnt_q <= '0;
                else if (count_en)
                    cnt_q <= cnt_q + CNT_W'(1);

                if (push)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    dir_q    <= mem[rd_ptr_q];
                end

                // Simultaneous push and pop leaves occupancy unchanged.
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Direction storage write port.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= key;
    end

    assign bus.dir       = dir_q;
    assign bus.move_tick = move_tick_q;
    assign bus.running   = running_q;
    assign bus.q_count   = count_q;
    assign bus.drop      = drop_q;

endmodule

// File: doc/snake_dir_scheduler.md
Name: snake_dir_scheduler

Overview:
- Sits between the PS/2 key decoder (one-cycle P_up/P_down/P_left/P_right pulses) and the snake movement engine.
- Filters illegal turns, buffers legal turns in a small FIFO and releases at most one direction change per game move tick.
- Owns the move-tick timebase and a run/pause/idle sequencer, so quick key bursts between ticks are neither lost nor applied twice.

Parameters:
TICK_DIV, 5000000, clk cycles per move tick (>=2)
QDEPTH, 4, direction FIFO depth (power of 2, >=2)
START_DIR, 2'd3, direction loaded on reset/game_over (0 up, 1 down, 2 left, 3 right)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
P_up  in  1  one-cycle key pulse
P_down  in  1  one-cycle key pulse
P_left  in  1  one-cycle key pulse
P_right  in  1  one-cycle key pulse
pause  in  1  one-cycle pulse, toggles RUN/PAUSE
game_over  in  1  level; forces IDLE and flush
dir  out  2  current snake direction
move_tick  out  1  one-cycle pulse, engine advances snake
running  out  1  1 while in RUN
q_count  out  clog2(QDEPTH)+1  FIFO occupancy
drop  out  1  one-cycle pulse, legal key lost because FIFO full

Behaviour:
- Reset on rising clk with rst=1:
  - dir=START_DIR, move_tick=0, running=0, q_count=0, drop=0.
  - Tick counter cnt=0, state=IDLE.
- Key select: at most one key per cycle, priority up>down>left>right. Encoded as k = 0/1/2/3.
- Reference direction ref = FIFO tail (last pushed) if q_count>0, else dir.
  - Both are taken from pre-edge values.
- Legality: reject k if k==ref or k is opposite of ref (k[1]==ref[1] && k[0]!=ref[0]).
  - Rejected keys cause no state change and no drop.
- Push: legal k is written if q_count<QDEPTH. If full, discard and pulse drop=1 for one cycle.
- States:
  - IDLE: cnt held 0, no ticks. First legal key is pushed, and state goes to RUN next cycle. pause ignored.
  - RUN: cnt increments each cycle. When cnt==TICK_DIV-1:
    - next cycle cnt=0 and move_tick=1.
    - If q_count>0 (pre-edge), head pops into dir in that same cycle, so dir is valid alongside move_tick.
    - If empty, dir unchanged.
    - pause pulse -> PAUSE.
  - PAUSE: cnt frozen (not cleared), no ticks, keys still filtered/pushed. pause pulse -> RUN, and counting resumes from the frozen value.
- game_over=1 (any state except during rst): next cycle state=IDLE, FIFO flushed (q_count=0), cnt=0, dir=START_DIR, move_tick=0.
  - game_over has priority over keys and pause in the same cycle.
- Simultaneous push and pop: both happen, q_count unchanged.
  - Legality uses the pre-pop tail. With q_count==1, ref is that single entry even though it is leaving.
  - Full FIFO with a pop in the same cycle still drops the key. Full is evaluated pre-edge.
- Key arriving in the same cycle cnt==TICK_DIV-1 into an empty FIFO: pushed only, not applied until the following tick.
- FIFO pointers wrap modulo QDEPTH. q_count never exceeds QDEPTH and never underflows.
- running = (state==RUN), registered.
- Latency:
  - key pulse -> q_count update: 1 cycle.
  - queued key -> dir: at the next move_tick.

Test Plan:
- Sim params TICK_DIV=4, QDEPTH=4, START_DIR=3.
- Reset, then P_up pulse -> q_count=1, running=1 one cycle later; move_tick every 4 cycles; first move_tick shows dir=0, q_count=0.
- In RUN with dir=3, pulse P_left then P_right -> both rejected (opposite, same); q_count stays 0, drop stays 0, dir stays 3 across ticks.
- Between ticks pulse up, left, down, right, up (queue empty, dir=3) -> ref chain gives up ok, left ok, down ok, right ok (q_count=4), then up legal but full -> drop=1; next four ticks yield dir=0,2,1,3.
- P_up and P_left in the same cycle (dir=3) -> only up accepted, q_count=1.
- In RUN with cnt=2, pulse pause -> no move_tick for 20 cycles and cnt stays at 2; pulse pause again -> move_tick exactly 2 cycles later.
- With q_count=3, assert game_over mid-run -> next cycle q_count=0, dir=3, running=0, no move_tick; rst=1 during RUN -> all outputs at reset values next cycle.
